mod_exp_sequencer: RTL and testbench
====================================

// Module: mod_exp_sequencer
// PURPOSE
//  Computes base^exponent mod modulus by left-to-right binary square-and-multiply.
//  Forms each WIDTHxWIDTH product internally and sends every reduction to one
//  external modulus unit over its ready/busy/valid handshake.
//  Sits between the key-generation/crypto control logic and the shared modulus datapath.
// PARAMETERS
//  WIDTH      16  operand/modulus width; the product sent for reduction is 2*WIDTH.
//  EXP_WIDTH  16  exponent width (>=1); all bits are processed, MSB first.
// PORTS
//  clk_in           in   1          clock.
//  rst_n_in         in   1          synchronous reset, active-low.
//  start_in         in   1          start request; sampled only in IDLE.
//  base_in          in   WIDTH      base; may be >= modulus.
//  exponent_in      in   EXP_WIDTH  exponent.
//  modulus_in       in   WIDTH      modulus.
//  result_out       out  WIDTH      result; held until the next accepted start.
//  busy_out         out  1          high from the cycle after start is accepted until valid_out.
//  valid_out        out  1          1-cycle pulse; result_out/error_out are valid in this cycle.
//  error_out        out  1          modulus was 0; held with result_out.
//  mod_ready_out    out  1          1-cycle request pulse to the modulus unit.
//  mod_value_out    out  2*WIDTH    dividend to reduce; held from the request until the response.
//  mod_modulus_out  out  WIDTH      captured modulus; held while busy_out is high.
//  mod_value_in     in   WIDTH      reduced value from the modulus unit.
//  mod_busy_in      in   1          modulus unit is busy.
//  mod_valid_in     in   1          modulus unit result pulse.
// BEHAVIOUR
//  Reset (rst_n_in=0 at a clock edge), applied regardless of state:
//   - state goes to IDLE; every output returns to 0.
//   - any in-flight modulus operation is abandoned; its later mod_valid_in is ignored.
//  Start (start_in=1 in IDLE):
//   - latch base, exponent and modulus into internal registers.
//   - result register R <- 1; bit index i <- EXP_WIDTH-1.
//   - busy_out=1 from the next cycle; error_out=0.
//   - start_in while busy is ignored.
//  Zero modulus: if modulus_in==0, go straight to DONE with result_out=0 and
//   error_out=1; no modulus requests are issued.
//  States: IDLE, REDUCE_B, SQUARE, MULT, DONE. Each of REDUCE_B, SQUARE, MULT has:
//   ISSUE: wait until mod_busy_in=0, then assert mod_ready_out for exactly one cycle
//          with mod_value_out driven.
//   WAIT:  hold mod_value_out until mod_valid_in=1, then capture mod_value_in.
//   - mod_valid_in outside WAIT is ignored.
//   - Exactly one request is outstanding at a time.
//  Operations:
//   - REDUCE_B: dividend = zero-extended base; B <- reduced value; then SQUARE.
//   - SQUARE:   dividend = R*R (full 2*WIDTH product); R <- reduced value.
//               If exponent[i]=1, go to MULT; otherwise advance.
//   - MULT:     dividend = R*B; R <- reduced value; then advance.
//   - Advance:  if i==0, go to DONE; otherwise i <- i-1 and go to SQUARE.
//  Request count and result:
//   - Exactly 1 + EXP_WIDTH + popcount(exponent) requests per job.
//   - Exponent 0 yields 1 mod m (0 when m=1) through the squarings; no special case.
//  DONE: result_out <- R; valid_out=1 for one cycle; busy_out=0 in that same cycle;
//   then IDLE. A new start is accepted in the cycle after DONE.
//  Overhead: at most 1 cycle between mod_valid_in and the next mod_ready_out,
//   given mod_busy_in=0.
// TESTING
//  1. base=4, exp=13, mod=497 -> result 445, error 0; exactly 20 mod_ready_out pulses.
//  2. base=20, exp=3, mod=7 (base > modulus) -> result 6.
//  3. base=3, exp=0, mod=7 -> result 1; base=10, exp=5, mod=1 -> result 0.
//  4. mod=0 -> valid_out pulse with error_out=1, result 0, no mod_ready_out pulses.
//  5. start_in held high throughout a busy job -> one job only; inputs changed
//     mid-job do not affect the result.
//  6. rst_n_in low during a WAIT phase -> all outputs 0 next cycle; a new job
//     (4,13,497) started after reset returns 445.

Source files
------------

// File: rtl/mod_exp_sequencer.sv
// Left-to-right square-and-multiply modular exponentiation. Each reduction is
// sent to a shared external modulus unit over a ready/busy/valid handshake.
module mod_exp_sequencer #(
  parameter int WIDTH     = 16,
  parameter int EXP_WIDTH = 16
) (
  input  logic                   clk_in,
  input  logic                   rst_n_in,
  input  logic                   start_in,
  input  logic [WIDTH-1:0]       base_in,
  input  logic [EXP_WIDTH-1:0]   exponent_in,
  input  logic [WIDTH-1:0]       modulus_in,
  output logic [WIDTH-1:0]       result_out,
  output logic                   busy_out,
  output logic                   valid_out,
  output logic                   error_out,
  output logic                   mod_ready_out,
  output logic [2*WIDTH-1:0]     mod_value_out,
  output logic [WIDTH-1:0]       mod_modulus_out,
  input  logic [WIDTH-1:0]       mod_value_in,
  input  logic                   mod_busy_in,
  input  logic                   mod_valid_in
);

  localparam int IW = (EXP_WIDTH > 1) ? $clog2(EXP_WIDTH) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REDUCE_B,
    S_SQUARE,
    S_MULT,
    S_DONE
  } state_t;

  state_t               state_q, state_d;
  logic                 wait_q, wait_d;   // 0: ISSUE phase, 1: WAIT phase
  logic [WIDTH-1:0]     b_q, m_q, r_q, result_q;
  logic [EXP_WIDTH-1:0] e_q;
  logic [IW-1:0]        i_q;
  logic                 error_q;

  logic                 in_op, accept, capture, last_bit;
  logic [2*WIDTH-1:0]   r_ext, b_ext;

  assign in_op    = (state_q == S_REDUCE_B) || (state_q == S_SQUARE) || (state_q == S_MULT);
  assign accept   = (state_q == S_IDLE) && start_in;
  assign capture  = in_op && wait_q && mod_valid_in;
  assign last_bit = (i_q == '0);
  assign r_ext    = {{WIDTH{1'b0}}, r_q};
  assign b_ext    = {{WIDTH{1'b0}}, b_q};

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of process order.
  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      state_q <= S_IDLE;
      wait_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  // NOTE: defaults at the top of a combinational block keep every path
  // assigned, so no latch is inferred for state_d / wait_d.
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    case (state_q)
      S_IDLE: begin
        wait_d = 1'b0;
        if (start_in) state_d = (modulus_in == '0) ? S_DONE : S_REDUCE_B;
      end
      S_REDUCE_B, S_SQUARE, S_MULT: begin
        if (!wait_q) begin
          if (!mod_busy_in) wait_d = 1'b1;
        end else if (mod_valid_in) begin
          wait_d = 1'b0;
          case (state_q)
            S_REDUCE_B: state_d = S_SQUARE;
            S_SQUARE:   state_d = e_q[i_q] ? S_MULT : (last_bit ? S_DONE : S_SQUARE);
            default:    state_d = last_bit ? S_DONE : S_SQUARE;
          endcase
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy_out        = in_op;
    valid_out       = (state_q == S_DONE);
    mod_ready_out   = in_op && !wait_q && !mod_busy_in;
    result_out      = result_q;
    error_out       = error_q;
    mod_modulus_out = m_q;
    case (state_q)
      S_REDUCE_B: mod_value_out = b_ext;
      S_SQUARE:   mod_value_out = r_ext * r_ext;
      S_MULT:     mod_value_out = r_ext * b_ext;
      default:    mod_value_out = '0;
    endcase
  end

  // NOTE: the operand registers are reset too, because every output
  // (including the held result and captured modulus) must read 0 after reset.
  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      b_q      <= '0;
      m_q      <= '0;
      r_q      <= '0;
      e_q      <= '0;
      i_q      <= '0;
      result_q <= '0;
      error_q  <= 1'b0;
    end else begin
      if (accept) begin
        b_q      <= base_in;
        e_q      <= exponent_in;
        m_q      <= modulus_in;
        r_q      <= WIDTH'(1);
        i_q      <= IW'(EXP_WIDTH - 1);
        result_q <= '0;
        error_q  <= (modulus_in == '0);
      end
      if (capture) begin
        if (state_q == S_REDUCE_B) b_q <= mod_value_in;
        else                       r_q <= mod_value_in;
        // Moving on to the next exponent bit
        if (state_q != S_REDUCE_B && state_d == S_SQUARE) i_q <= i_q - 1'b1;
        if (state_d == S_DONE) result_q <= mod_value_in;
      end
    end
  end

endmodule

// File: tb/tb_mod_exp_sequencer.sv
// Directed bench for mod_exp_sequencer with a behavioural modulus unit that
// answers each request after a fixed busy latency.
module tb_mod_exp_sequencer;

  localparam int W  = 16;
  localparam int EW = 16;
  localparam int LAT = 3;

  logic            clk_in = 1'b0;
  logic            rst_n_in = 1'b0;
  logic            start_in = 1'b0;
  logic [W-1:0]    base_in = '0;
  logic [EW-1:0]   exponent_in = '0;
  logic [W-1:0]    modulus_in = '0;
  logic [W-1:0]    result_out;
  logic            busy_out, valid_out, error_out, mod_ready_out;
  logic [2*W-1:0]  mod_value_out;
  logic [W-1:0]    mod_modulus_out;
  logic [W-1:0]    mod_value_in = '0;
  logic            mod_busy_in = 1'b0;
  logic            mod_valid_in = 1'b0;

  int n_compared = 0;
  int n_mismatched = 0;
  int req_cnt = 0;

  mod_exp_sequencer #(.WIDTH(W), .EXP_WIDTH(EW)) dut (
    .clk_in          (clk_in),
    .rst_n_in        (rst_n_in),
    .start_in        (start_in),
    .base_in         (base_in),
    .exponent_in     (exponent_in),
    .modulus_in      (modulus_in),
    .result_out      (result_out),
    .busy_out        (busy_out),
    .valid_out       (valid_out),
    .error_out       (error_out),
    .mod_ready_out   (mod_ready_out),
    .mod_value_out   (mod_value_out),
    .mod_modulus_out (mod_modulus_out),
    .mod_value_in    (mod_value_in),
    .mod_busy_in     (mod_busy_in),
    .mod_valid_in    (mod_valid_in)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Modulus unit: busy for LAT cycles after a request, then a one-cycle valid.
  initial begin : modulus_unit
    logic [2*W-1:0] val;
    logic [W-1:0]   m;
    forever begin
      @(negedge clk_in);
      mod_valid_in = 1'b0;
      if (mod_ready_out) begin
        val = mod_value_out;
        m   = mod_modulus_out;
        req_cnt++;
        @(negedge clk_in);
        mod_busy_in = 1'b1;
        repeat (LAT) @(negedge clk_in);
        mod_busy_in  = 1'b0;
        mod_value_in = (m == '0) ? '0 : W'(val % {{W{1'b0}}, m});
        mod_valid_in = 1'b1;
      end
    end
  end

  task automatic run_job(input logic [W-1:0] b, input logic [EW-1:0] e,
                         input logic [W-1:0] m, input bit hold,
                         output logic [W-1:0] res, output logic err,
                         output logic busy_at_valid, output logic busy_after_start);
    bit seen = 0;
    @(negedge clk_in);
    base_in = b; exponent_in = e; modulus_in = m;
    start_in = 1'b1;
    req_cnt = 0;
    @(negedge clk_in);
    busy_after_start = busy_out;
    if (!hold) start_in = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if (valid_out) begin seen = 1; break; end
      if (hold && c == 5) begin base_in = 1; exponent_in = 0; modulus_in = 3; end
      @(negedge clk_in);
    end
    start_in = 1'b0;
    if (!seen) check("valid_timeout", 0, 1);
    res = result_out;
    err = error_out;
    busy_at_valid = busy_out;
  endtask

  initial begin : stim
    logic [W-1:0] res;
    logic err, bv, bs;
    int cnt_before;

    repeat (3) @(negedge clk_in);
    check("reset_outputs", {result_out, busy_out, valid_out, error_out, mod_ready_out,
                            mod_value_out, mod_modulus_out}, 0);
    rst_n_in = 1'b1;

    // 1: 4^13 mod 497
    run_job(4, 13, 497, 0, res, err, bv, bs);
    check("t1_result", res, 445);
    check("t1_error", err, 0);
    check("t1_requests", req_cnt, 20);
    check("t1_busy_after_start", bs, 1);
    check("t1_busy_at_valid", bv, 0);
    @(negedge clk_in);
    check("t1_valid_one_cycle", valid_out, 0);
    check("t1_result_held", result_out, 445);

    // 2: base larger than modulus
    run_job(20, 3, 7, 0, res, err, bv, bs);
    check("t2_result", res, 6);
    check("t2_requests", req_cnt, 19);

    // 3: exponent 0 and modulus 1
    run_job(3, 0, 7, 0, res, err, bv, bs);
    check("t3a_result", res, 1);
    check("t3a_requests", req_cnt, 17);
    run_job(10, 5, 1, 0, res, err, bv, bs);
    check("t3b_result", res, 0);
    check("t3b_error", err, 0);

    // 4: zero modulus
    run_job(9, 7, 0, 0, res, err, bv, bs);
    check("t4_error", err, 1);
    check("t4_result", res, 0);
    check("t4_requests", req_cnt, 0);
    check("t4_busy", bs, 0);

    // 5: start held high, inputs changed mid-job
    run_job(4, 13, 497, 1, res, err, bv, bs);
    check("t5_result", res, 445);
    check("t5_requests", req_cnt, 20);
    cnt_before = req_cnt;
    begin
      int busy_seen = 0;
      repeat (20) begin @(negedge clk_in); if (busy_out) busy_seen++; end
      check("t5_no_second_job", busy_seen, 0);
    end
    check("t5_no_extra_requests", req_cnt, cnt_before);

    // 6: reset during a WAIT phase
    @(negedge clk_in);
    base_in = 4; exponent_in = 13; modulus_in = 497; start_in = 1'b1; req_cnt = 0;
    @(negedge clk_in);
    start_in = 1'b0;
    for (int c = 0; c < 500 && req_cnt < 3; c++) @(negedge clk_in);
    check("t6_reached_wait", req_cnt, 3);
    @(negedge clk_in);
    rst_n_in = 1'b0;
    @(negedge clk_in);
    check("t6_reset_outputs", {result_out, busy_out, valid_out, error_out, mod_ready_out,
                               mod_value_out, mod_modulus_out}, 0);
    rst_n_in = 1'b1;
    repeat (12) @(negedge clk_in);
    check("t6_idle_after_stale_valid", {busy_out, valid_out}, 0);
    run_job(4, 13, 497, 0, res, err, bv, bs);
    check("t6_result", res, 445);
    check("t6_requests", req_cnt, 20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
